disp_clk_gen: RTL

- Parametrised successor to the fixed 30000-cycle display scan-clock divider.
- Generates a square scan clock `show_clk` for the 7-segment/LED display mux, plus a one-cycle `tick` strobe.
- Half-period is reset-defaulted by parameter and reloadable at run time; adds an enable/pause.
- Sits between the board clock and the display scan logic.

---
 rtl/disp_clk_if.sv | 27 ++
 rtl/disp_clk_gen.sv | 64 ++++++
 2 files changed

// File: rtl/disp_clk_if.sv
// disp_clk_if: control and output bundle of the display scan-clock generator.
// Carries the extra hi_in_i duty input when DISP_CLK_DUTY_EN is defined.
interface disp_clk_if #(parameter int CNT_W = 32);
  logic             en_i;
  logic             load_i;
  logic [CNT_W-1:0] half_in_i;
`ifdef DISP_CLK_DUTY_EN
  logic [CNT_W-1:0] hi_in_i;
`endif
  logic             show_clk_o;
  logic             tick_o;
  logic [CNT_W-1:0] half_q_o;
  modport master (
    output en_i, load_i, half_in_i,
`ifdef DISP_CLK_DUTY_EN
    output hi_in_i,
`endif
    input  show_clk_o, tick_o, half_q_o
  );
  modport slave (
    input  en_i, load_i, half_in_i,
`ifdef DISP_CLK_DUTY_EN
    input  hi_in_i,
`endif
    output show_clk_o, tick_o, half_q_o
  );
endinterface

// File: rtl/disp_clk_gen.sv
// disp_clk_gen: reloadable display scan clock with rising-edge tick and enable/pause.
// DISP_CLK_DUTY_EN adds a programmable high time (hi_in_i); undefined gives 50% duty.
module disp_clk_gen #(
  parameter int CNT_W    = 32,
  parameter int DEF_HALF = 15000
) (
  input logic       clk,
  input logic       rst,
  disp_clk_if.slave bus
);
  localparam logic [CNT_W-1:0] DEF_H = CNT_W'((DEF_HALF < 1) ? 1 : DEF_HALF);
  localparam logic [CNT_W:0]   ONE   = (CNT_W+1)'(1);
  logic [CNT_W:0]   cnt_q, cnt_d, cnt_nx, period, thr;
  logic [CNT_W-1:0] half_q, half_d, half_ld;
  logic             show_q, show_d, tick_q, tick_d, tick_ok;
  assign period  = {half_q, 1'b0};
  assign cnt_nx  = (cnt_q == period - ONE) ? '0 : cnt_q + ONE;
  assign half_ld = (bus.half_in_i == '0) ? CNT_W'(1) : bus.half_in_i;
`ifdef DISP_CLK_DUTY_EN
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W:0]   hi_max;
  // clamp only truncates when hi_max < hi_in_i, so it always fits CNT_W bits
  assign hi_max  = {half_ld, 1'b0};
  assign hi_d    = ({1'b0, bus.hi_in_i} > hi_max) ? hi_max[CNT_W-1:0] : bus.hi_in_i;
  assign thr     = period - {1'b0, hi_q};
  assign tick_ok = hi_q != '0;
  always_ff @(posedge clk)
    hi_q <= rst ? DEF_H : bus.load_i ? hi_d : hi_q;
`else
  assign thr     = {1'b0, half_q};
  assign tick_ok = 1'b1;
`endif
  always_comb begin
    cnt_d  = cnt_q;
    half_d = half_q;
    show_d = show_q;
    tick_d = 1'b0;
    if (bus.load_i) begin
      cnt_d  = '0;
      half_d = half_ld;
      show_d = 1'b0;
    end else if (bus.en_i) begin
      cnt_d  = cnt_nx;
      show_d = cnt_nx >= thr;
      tick_d = (cnt_nx == thr) && tick_ok;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      half_q <= DEF_H;
      show_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      half_q <= half_d;
      show_q <= show_d;
      tick_q <= tick_d;
    end
  end
  assign bus.show_clk_o = show_q;
  assign bus.tick_o     = tick_q;
  assign bus.half_q_o   = half_q;
endmodule
